// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the snake-game VGA path.
//   - Object codes returned by the game logic for each scanned pixel.
//   - Default 640x480@60 timing (25 MHz pixel clock).
//   - Colour selector used by the render stage.
package vga_pkg;

  localparam logic [1:0] OBJ_NONE = 2'b00;
  localparam logic [1:0] OBJ_HEAD = 2'b01;
  localparam logic [1:0] OBJ_BODY = 2'b10;
  localparam logic [1:0] OBJ_WALL = 2'b11;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  typedef enum logic [2:0] {
    COL_BG,
    COL_WALL,
    COL_HEAD,
    COL_BODY,
    COL_APPLE_RED,
    COL_APPLE_GREEN
  } color_sel_e;

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: horizontal/vertical scan counters and raw (stage 0) timing.
//   clk, rst_n   : pixel clock, async active-low reset
//   h_cnt, v_cnt : current scan position
//   active       : position lies inside the visible area
//   hsync_act    : horizontal sync pulse window (active-high, polarity applied later)
//   vsync_act    : vertical sync pulse window (active-high)
//   frame_origin : position is (0,0)
//   blink_phase  : bit 4 of the 5-bit frame counter
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hsync_act,
  output logic       vsync_act,
  output logic       frame_origin,
  output logic       blink_phase
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  logic [4:0] frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_cnt == 10'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == 10'(V_TOTAL - 1)) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 5'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // 11-bit compares so a boundary of exactly 1024 does not alias to 0.
  always_comb begin
    active       = ({1'b0, h_cnt} < 11'(H_ACTIVE)) && ({1'b0, v_cnt} < 11'(V_ACTIVE));
    hsync_act    = ({1'b0, h_cnt} >= 11'(H_ACTIVE + H_FP)) &&
                   ({1'b0, h_cnt} <  11'(H_ACTIVE + H_FP + H_SYNC));
    vsync_act    = ({1'b0, v_cnt} >= 11'(V_ACTIVE + V_FP)) &&
                   ({1'b0, v_cnt} <  11'(V_ACTIVE + V_FP + V_SYNC));
    frame_origin = (h_cnt == '0) && (v_cnt == '0);
    blink_phase  = frame_cnt[4];
  end

endmodule

// File: rtl/vga_render_pipe.sv
// vga_render_pipe: VGA timing plus two-stage pixel render pipeline.
//   Clk_25mhz, Rst_n      : pixel clock, async active-low reset
//   Object                : game object for the Pixel_x/Pixel_y of the previous cycle
//   Apple_x/_y/_type/_valid : packed per-channel apple position, colour, enable
//   Blink_en              : hide apples during the upper half of the 32-frame cycle
//   Pixel_x, Pixel_y      : scan position handed to the game logic (stage 0)
//   Hsync_sig, Vsync_sig, Video_de, Frame_start, Vga_red/green/blue : stage 2,
//                           all aligned, two cycles after the matching Pixel_x/y
module vga_render_pipe
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic        SYNC_POL   = 1'b0,
  parameter int unsigned COLOR_W    = 4,
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned N_APPLE    = 2
) (
  input  logic                 Clk_25mhz,
  input  logic                 Rst_n,
  input  logic [1:0]           Object,
  input  logic [N_APPLE*6-1:0] Apple_x,
  input  logic [N_APPLE*5-1:0] Apple_y,
  input  logic [N_APPLE-1:0]   Apple_type,
  input  logic [N_APPLE-1:0]   Apple_valid,
  input  logic                 Blink_en,
  output logic [9:0]           Pixel_x,
  output logic [9:0]           Pixel_y,
  output logic                 Hsync_sig,
  output logic                 Vsync_sig,
  output logic                 Video_de,
  output logic                 Frame_start,
  output logic [COLOR_W-1:0]   Vga_red,
  output logic [COLOR_W-1:0]   Vga_green,
  output logic [COLOR_W-1:0]   Vga_blue
);

  localparam logic [COLOR_W-1:0] C_MAX  = '1;
  localparam logic [COLOR_W-1:0] C_HALF = C_MAX >> 1;

  logic       active_s0, hsync_s0, vsync_s0, origin_s0, blink_s0;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk          (Clk_25mhz),
    .rst_n        (Rst_n),
    .h_cnt        (Pixel_x),
    .v_cnt        (Pixel_y),
    .active       (active_s0),
    .hsync_act    (hsync_s0),
    .vsync_act    (vsync_s0),
    .frame_origin (origin_s0),
    .blink_phase  (blink_s0)
  );

  // Stage 1: hold the pixel whose Object is arriving this cycle.
  logic [9:0] px_s1, py_s1;
  logic       active_s1, hsync_s1, vsync_s1, origin_s1, blink_s1;

  always_ff @(posedge Clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      px_s1     <= '0;
      py_s1     <= '0;
      active_s1 <= 1'b0;
      hsync_s1  <= 1'b0;
      vsync_s1  <= 1'b0;
      origin_s1 <= 1'b0;
      blink_s1  <= 1'b0;
    end else begin
      px_s1     <= Pixel_x;
      py_s1     <= Pixel_y;
      active_s1 <= active_s0;
      hsync_s1  <= hsync_s0;
      vsync_s1  <= vsync_s0;
      origin_s1 <= origin_s0;
      blink_s1  <= blink_s0;
    end
  end

  // Apple lookup against the stage-1 pixel; lowest matching channel wins.
  logic [9:0] cell_x, cell_y;
  logic       apple_hit, apple_green;

  always_comb begin
    cell_x      = px_s1 >> CELL_SHIFT;
    cell_y      = py_s1 >> CELL_SHIFT;
    apple_hit   = 1'b0;
    apple_green = 1'b0;
    for (int unsigned i = 0; i < N_APPLE; i++) begin
      if (!apple_hit && Apple_valid[i] &&
          cell_x == 10'(Apple_x[6*i +: 6]) &&
          cell_y == 10'(Apple_y[5*i +: 5])) begin
        apple_hit   = 1'b1;
        apple_green = Apple_type[i];
      end
    end
  end

  color_sel_e sel;

  always_comb begin
    sel = COL_BG;
    if (active_s1) begin
      if (Object == OBJ_WALL)      sel = COL_WALL;
      else if (Object == OBJ_HEAD) sel = COL_HEAD;
      else if (Object == OBJ_BODY) sel = COL_BODY;
      else if (apple_hit && !(Blink_en && blink_s1))
        sel = apple_green ? COL_APPLE_GREEN : COL_APPLE_RED;
    end
  end

  logic [COLOR_W-1:0] red_n, green_n, blue_n;

  always_comb begin
    red_n   = '0;
    green_n = '0;
    blue_n  = '0;
    case (sel)
      COL_WALL:        blue_n  = C_MAX;
      COL_HEAD:        begin red_n = C_MAX; green_n = C_MAX; end
      COL_BODY:        green_n = C_MAX;
      COL_APPLE_RED:   red_n   = C_MAX;
      COL_APPLE_GREEN: green_n = C_HALF;
      default:         ;
    endcase
  end

  // Stage 2: registered outputs, sync polarity applied here.
  always_ff @(posedge Clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      Hsync_sig   <= ~SYNC_POL;
      Vsync_sig   <= ~SYNC_POL;
      Video_de    <= 1'b0;
      Frame_start <= 1'b0;
      Vga_red     <= '0;
      Vga_green   <= '0;
      Vga_blue    <= '0;
    end else begin
      Hsync_sig   <= hsync_s1 ? SYNC_POL : ~SYNC_POL;
      Vsync_sig   <= vsync_s1 ? SYNC_POL : ~SYNC_POL;
      Video_de    <= active_s1;
      Frame_start <= origin_s1;
      Vga_red     <= red_n;
      Vga_green   <= green_n;
      Vga_blue    <= blue_n;
    end
  end

endmodule
